// File: rtl/eval_stack_param.sv
// Parameterised evaluation stack: a count-indexed register array with
// PUSH/POP/POPPUSH/SWAP, combinational top-two reads and sticky error flags.
module eval_stack_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_act,
  input  logic [1:0]       es_op,
  input  logic             pop_num,
  input  logic [WIDTH-1:0] push_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_POPPUSH = 2'b10;
  localparam logic [1:0] OP_SWAP    = 2'b11;

  logic [WIDTH-1:0] stack_reg [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             overflow_reg;
  logic             underflow_reg;

  logic [31:0]      cnt32;
  logic [31:0]      pop_n;
  logic             is_push, is_pop, is_pp, is_swap;
  logic             push_ok, pop_ok, pp_ok, swap_ok;
  logic             ovf_evt, unf_evt;
  logic [WIDTH-1:0] a_val, b_val;
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] wr_data [DEPTH];

  // Widened count keeps index comparisons free of truncation effects.
  assign cnt32 = 32'(count_reg);
  assign pop_n = pop_num ? 32'd2 : 32'd1;

  assign is_push = es_act && (es_op == OP_PUSH);
  assign is_pop  = es_act && (es_op == OP_POP);
  assign is_pp   = es_act && (es_op == OP_POPPUSH);
  assign is_swap = es_act && (es_op == OP_SWAP);

  assign push_ok = is_push && (cnt32 < 32'(DEPTH));
  assign pop_ok  = is_pop  && (cnt32 >= pop_n);
  assign pp_ok   = is_pp   && (cnt32 >= pop_n);
  assign swap_ok = is_swap && (cnt32 >= 32'd2);

  assign ovf_evt = is_push && !push_ok;
  assign unf_evt = ((is_pop || is_pp) && (cnt32 < pop_n)) || (is_swap && !swap_ok);

  always_comb begin
    a_val = '0;
    b_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt32 == 32'(i + 1)) a_val = stack_reg[i];
      if (cnt32 == 32'(i + 2)) b_val = stack_reg[i];
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok)      count_next = count_reg + 1'b1;
    else if (pop_ok)  count_next = count_reg - CW'(pop_n);
    else if (pp_ok)   count_next = count_reg - CW'(pop_n) + 1'b1;
  end

  // Each slot decides on its own whether it is the target of this cycle's write;
  // a SWAP writes two slots at once with the other's old value.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hit_push, hit_pp, hit_top, hit_below;
      assign hit_push  = push_ok && (cnt32 == 32'(gi));
      assign hit_pp    = pp_ok   && (cnt32 == 32'(gi) + pop_n);
      assign hit_top   = swap_ok && (cnt32 == 32'(gi + 1));
      assign hit_below = swap_ok && (cnt32 == 32'(gi + 2));
      assign wr_en[gi]   = hit_push || hit_pp || hit_top || hit_below;
      assign wr_data[gi] = hit_top ? b_val : (hit_below ? a_val : push_in);
    end
  endgenerate

  // Contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset && wr_en[i]) stack_reg[i] <= wr_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= ovf_evt || (overflow_reg && !err_clr);
      underflow_reg <= unf_evt || (underflow_reg && !err_clr);
    end
  end

  assign a_out     = a_val;
  assign b_out     = b_val;
  assign count     = count_reg;
  assign empty     = (count_reg == '0);
  assign full      = (cnt32 == 32'(DEPTH));
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
